// File: rtl/fp_mul_seq_pkg.sv
// ============================================================================
// fp_mul_seq_pkg : shared widths, bias and FSM encoding for fp_mul_seq
// Rev 1.0
// ============================================================================
`default_nettype none

package fp_mul_seq_pkg;

  localparam int FP_EXP_W  = 8;
  localparam int FP_MANT_W = 24;
  localparam int FP_BIAS   = 127;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/fp_shift_add_mult.sv
// ============================================================================
// fp_shift_add_mult : iterative shift-add mantissa multiplier, one bit/clock
// Rev 1.0
// ============================================================================
`default_nettype none

module fp_shift_add_mult #(
  parameter int MANT_W = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  step,
  input  logic [MANT_W-1:0]     mcand_in,
  input  logic [MANT_W-1:0]     mplier_in,
  output logic [2*MANT_W-1:0]   product,
  output logic                  last
);

  localparam int CNT_W = $clog2(MANT_W) + 1;

  logic [2*MANT_W-1:0] acc_q, acc_d;
  logic [MANT_W-1:0]   mcand_q, mcand_d;
  logic [MANT_W-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (load) begin
      acc_d    = '0;
      mcand_d  = mcand_in;
      mplier_d = mplier_in;
      cnt_d    = '0;
    end else if (step) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + ({{MANT_W{1'b0}}, mcand_q} << cnt_q);
      end
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign product = acc_q;
  assign last    = (cnt_q == CNT_W'(MANT_W - 1));

endmodule

`default_nettype wire

// File: rtl/fp_mul_seq.sv
// ============================================================================
// fp_mul_seq : sequential single-precision multiply of decoded operand fields
// Rev 1.0
// ============================================================================
`default_nettype none

module fp_mul_seq
  import fp_mul_seq_pkg::*;
#(
  parameter int EXP_W  = FP_EXP_W,
  parameter int MANT_W = FP_MANT_W,
  parameter int BIAS   = FP_BIAS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              signoA,
  input  logic [EXP_W-1:0]  exponenteA,
  input  logic [MANT_W-1:0] mantissaA,
  input  logic              signoB,
  input  logic [EXP_W-1:0]  exponenteB,
  input  logic [MANT_W-1:0] mantissaB,
  output logic              busy,
  output logic              done,
  output logic              signoR,
  output logic [EXP_W-1:0]  exponenteR,
  output logic [MANT_W-1:0] mantissaR,
  output logic              overflow,
  output logic              underflow
);

  localparam int EW2 = EXP_W + 2;
  localparam logic signed [EW2-1:0] E_MAX  = EW2'((1 << EXP_W) - 1);
  localparam logic signed [EW2-1:0] E_ZERO = '0;

  state_e state_q, state_d;

  logic              sign_op_q, sign_op_d;
  logic [EXP_W-1:0]  ea_q, ea_d, eb_q, eb_d;
  logic              sign_q, sign_d;
  logic [EXP_W-1:0]  exp_q, exp_d;
  logic [MANT_W-1:0] mant_q, mant_d;
  logic              ovf_q, ovf_d, unf_q, unf_d;

  logic                load, step, last;
  logic [2*MANT_W-1:0] prod;
  logic signed [EW2-1:0] e_raw, e_fin;
  logic [MANT_W-1:0]   mant_norm;
  logic                unused_prod_low;

  fp_shift_add_mult #(.MANT_W(MANT_W)) u_mult (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .step      (step),
    .mcand_in  (mantissaA),
    .mplier_in (mantissaB),
    .product   (prod),
    .last      (last)
  );

  // Product of two [1,2) mantissas lies in [1,4); top bit set means the extra
  // integer bit must be absorbed into the exponent.
  always_comb begin
    e_raw     = EW2'(ea_q) + EW2'(eb_q) - EW2'(BIAS);
    e_fin     = e_raw + EW2'(prod[2*MANT_W-1]);
    mant_norm = prod[2*MANT_W-1] ? prod[2*MANT_W-1:MANT_W] : prod[2*MANT_W-2:MANT_W-1];
  end

  assign unused_prod_low = ^prod[MANT_W-2:0];

  always_comb begin
    state_d   = state_q;
    sign_op_d = sign_op_q;
    ea_d      = ea_q;
    eb_d      = eb_q;
    sign_d    = sign_q;
    exp_d     = exp_q;
    mant_d    = mant_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    load      = 1'b0;
    step      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          sign_op_d = signoA ^ signoB;
          ea_d      = exponenteA;
          eb_d      = exponenteB;
          state_d   = MULT;
        end
      end
      MULT: begin
        step = 1'b1;
        if (last) state_d = NORM;
      end
      NORM: begin
        sign_d = sign_op_q;
        if (e_fin >= E_MAX) begin
          ovf_d  = 1'b1;
          unf_d  = 1'b0;
          exp_d  = {EXP_W{1'b1}};
          mant_d = {1'b1, {(MANT_W-1){1'b0}}};
        end else if (e_fin <= E_ZERO) begin
          ovf_d  = 1'b0;
          unf_d  = 1'b1;
          exp_d  = '0;
          mant_d = '0;
        end else begin
          ovf_d  = 1'b0;
          unf_d  = 1'b0;
          exp_d  = e_fin[EXP_W-1:0];
          mant_d = mant_norm;
        end
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sign_op_q <= 1'b0;
      ea_q      <= '0;
      eb_q      <= '0;
      sign_q    <= 1'b0;
      exp_q     <= '0;
      mant_q    <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sign_op_q <= sign_op_d;
      ea_q      <= ea_d;
      eb_q      <= eb_d;
      sign_q    <= sign_d;
      exp_q     <= exp_d;
      mant_q    <= mant_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign signoR     = sign_q;
  assign exponenteR = exp_q;
  assign mantissaR  = mant_q;
  assign overflow   = ovf_q;
  assign underflow  = unf_q;

endmodule

`default_nettype wire

// File: tb/tb_fp_mul_seq.sv
// ============================================================================
// tb_fp_mul_seq : directed vectors with queue scoreboard for fp_mul_seq
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fp_mul_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        signoA = 1'b0, signoB = 1'b0;
  logic [7:0]  exponenteA = '0, exponenteB = '0;
  logic [23:0] mantissaA = '0, mantissaB = '0;
  logic        busy, done, signoR, overflow, underflow;
  logic [7:0]  exponenteR;
  logic [23:0] mantissaR;

  fp_mul_seq dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signoA     (signoA),
    .exponenteA (exponenteA),
    .mantissaA  (mantissaA),
    .signoB     (signoB),
    .exponenteB (exponenteB),
    .mantissaB  (mantissaB),
    .busy       (busy),
    .done       (done),
    .signoR     (signoR),
    .exponenteR (exponenteR),
    .mantissaR  (mantissaR),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic [7:0]  e;
    logic [23:0] m;
    logic        ov;
    logic        un;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"},  64'(busy), 64'd0);
    check({tag, "_done"},  64'(done), 64'd0);
    check({tag, "_sign"},  64'(signoR), 64'd0);
    check({tag, "_exp"},   64'(exponenteR), 64'd0);
    check({tag, "_mant"},  64'(mantissaR), 64'd0);
    check({tag, "_ovf"},   64'(overflow), 64'd0);
    check({tag, "_unf"},   64'(underflow), 64'd0);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      done_cnt++;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done at cycle %0d got done=1 expected none", cyc);
      end else begin
        e = sb_q.pop_front();
        check("signoR",     64'(signoR), 64'(e.s));
        check("exponenteR", 64'(exponenteR), 64'(e.e));
        check("mantissaR",  64'(mantissaR), 64'(e.m));
        check("overflow",   64'(overflow), 64'(e.ov));
        check("underflow",  64'(underflow), 64'(e.un));
        check("latency",    64'(cyc - e.cyc), 64'd25);
        check("busy_at_done", 64'(busy), 64'd1);
      end
    end
  end

  task automatic issue(input logic sa, input logic [7:0] ea, input logic [23:0] ma,
                       input logic sb, input logic [7:0] eb, input logic [23:0] mb,
                       input logic push, input logic es, input logic [7:0] ee,
                       input logic [23:0] em, input logic eo, input logic eu);
    exp_t x;
    @(negedge clk);
    signoA = sa; exponenteA = ea; mantissaA = ma;
    signoB = sb; exponenteB = eb; mantissaB = mb;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    signoA = 1'($urandom); exponenteA = 8'($urandom); mantissaA = 24'($urandom);
    signoB = 1'($urandom); exponenteB = 8'($urandom); mantissaB = 24'($urandom);
    if (push) begin
      x.s = es; x.e = ee; x.m = em; x.ov = eo; x.un = eu; x.cyc = cyc;
      sb_q.push_back(x);
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((sb_q.size() != 0 || busy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout got busy=%0d pending=%0d expected idle", name, busy, sb_q.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // 1.5 x 2.0 = 3.0
    issue(1'b0, 8'd127, 24'hC00000, 1'b0, 8'd128, 24'h800000,
          1'b1, 1'b0, 8'd128, 24'hC00000, 1'b0, 1'b0);
    check("busy_after_start", 64'(busy), 64'd1);
    wait_idle("t1");

    // -1.0 x 1.0
    issue(1'b1, 8'd127, 24'h800000, 1'b0, 8'd127, 24'h800000,
          1'b1, 1'b1, 8'd127, 24'h800000, 1'b0, 1'b0);
    wait_idle("t2");

    // 1.5 x 1.5 = 2.25, product carries into bit 47
    issue(1'b0, 8'd127, 24'hC00000, 1'b0, 8'd127, 24'hC00000,
          1'b1, 1'b0, 8'd128, 24'h900000, 1'b0, 1'b0);
    wait_idle("t3");

    // exponent overflow: 254+254-127 = 381
    issue(1'b0, 8'hFE, 24'h800000, 1'b1, 8'hFE, 24'h800000,
          1'b1, 1'b1, 8'hFF, 24'h800000, 1'b1, 1'b0);
    wait_idle("t4a");

    // exponent underflow: 1+1-127 = -125
    issue(1'b0, 8'h01, 24'h800000, 1'b0, 8'h01, 24'h800000,
          1'b1, 1'b0, 8'h00, 24'h000000, 1'b0, 1'b1);
    wait_idle("t4b");

    // start while busy is ignored
    issue(1'b0, 8'd127, 24'hC00000, 1'b0, 8'd127, 24'hC00000,
          1'b1, 1'b0, 8'd128, 24'h900000, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    issue(1'b1, 8'd130, 24'hA00000, 1'b0, 8'd100, 24'hF00000,
          1'b0, 1'b0, 8'd0, 24'd0, 1'b0, 1'b0);
    wait_idle("t5");
    repeat (5) @(negedge clk);
    check("hold_exp",  64'(exponenteR), 64'd128);
    check("hold_mant", 64'(mantissaR), 64'h900000);

    // reset mid-operation discards it
    issue(1'b0, 8'd128, 24'h800000, 1'b1, 8'd127, 24'hC00000,
          1'b1, 1'b1, 8'd128, 24'hC00000, 1'b0, 1'b0);
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_zero_outputs("midrst");
    sb_q.delete();
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("idle_after_rst", 64'(busy), 64'd0);

    // fresh operation after reset: 2.0 x -1.5 = -3.0
    issue(1'b0, 8'd128, 24'h800000, 1'b1, 8'd127, 24'hC00000,
          1'b1, 1'b1, 8'd128, 24'hC00000, 1'b0, 1'b0);
    wait_idle("t6");
    repeat (3) @(negedge clk);
    check("done_count", 64'(done_cnt), 64'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
